// File: rtl/io_port_if.sv
// Bundles the processor port datapath and the device handshakes of io_port_bridge.
// The slave modport is the bridge side. The master modport is the processor plus device side.
interface io_port_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 3
);
    logic              cpu_out_wr;
    logic [DATA_W-1:0] cpu_out_data;
    logic              out_full;
    logic [CNT_W-1:0]  out_count;
    logic              dev_out_valid;
    logic [DATA_W-1:0] dev_out_data;
    logic              dev_out_ready;
    logic              dev_in_valid;
    logic [DATA_W-1:0] dev_in_data;
    logic              dev_in_ready;
    logic              cpu_in_rd;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_avail;
    logic              err_clr;
    logic              out_overflow;
    logic              in_underrun;

    modport slave (
        input  cpu_out_wr, cpu_out_data, dev_out_ready, dev_in_valid, dev_in_data,
               cpu_in_rd, err_clr,
        output out_full, out_count, dev_out_valid, dev_out_data, dev_in_ready,
               cpu_in_data, cpu_in_avail, out_overflow, in_underrun
    );

    modport master (
        output cpu_out_wr, cpu_out_data, dev_out_ready, dev_in_valid, dev_in_data,
               cpu_in_rd, err_clr,
        input  out_full, out_count, dev_out_valid, dev_out_data, dev_in_ready,
               cpu_in_data, cpu_in_avail, out_overflow, in_underrun
    );
endinterface

// File: rtl/io_port_bridge.sv
// Bridges the processor OUT/IN port datapath to an external device.
// Outbound words pass through a show-ahead FIFO.
// Inbound words pass through a one-entry holding register that is controlled by a two-state FSM.
module io_port_bridge #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = $clog2(OUT_DEPTH) + 1
) (
    input logic     clk,
    input logic     rst,
    io_port_if.slave bus
);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    typedef enum logic {IN_EMPTY, IN_FULL} inState_t;

    logic [DATA_W-1:0] outMem [OUT_DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  count;
    logic              fifoFull, push, pop, dropWrite;

    inState_t          inState, nextState;
    logic              capture, underrunEvt;
    logic [DATA_W-1:0] heldData;
    logic              overflowFlag, underrunFlag;

    // A full FIFO accepts a write only if it is draining in the same cycle.
    // dev_out_ready affects push acceptance only. It does not affect out_full.
    assign fifoFull  = (count == CNT_W'(OUT_DEPTH));
    assign pop       = (count != '0) && bus.dev_out_ready;
    assign push      = bus.cpu_out_wr && (!fifoFull || pop);
    assign dropWrite = bus.cpu_out_wr && fifoFull && !pop;

    assign bus.out_full      = fifoFull;
    assign bus.out_count     = count;
    assign bus.dev_out_valid = (count != '0);
    assign bus.dev_out_data  = outMem[rdPtr];
    assign bus.cpu_in_data   = heldData;
    assign bus.out_overflow  = overflowFlag;
    assign bus.in_underrun   = underrunFlag;

    // Storage write. The FIFO storage has no reset and only writes on push.
    // NOTE: storage arrays are not reset; valid-ness is tracked by count, so a reset here only costs logic.
    always_ff @(posedge clk) begin
        if (push) outMem[wrPtr] <= bus.cpu_out_data;
    end

    // The FIFO pointers and occupancy count. The pointers wrap modulo OUT_DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The input FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inState <= IN_EMPTY;
        else     inState <= nextState;
    end

    // The input FSM next state and handshake outputs. These depend on the state only, so there is no path from valid to ready.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        nextState        = inState;
        bus.dev_in_ready = 1'b0;
        bus.cpu_in_avail = 1'b0;
        capture          = 1'b0;
        underrunEvt      = 1'b0;
        case (inState)
            IN_EMPTY: begin
                bus.dev_in_ready = 1'b1;
                underrunEvt      = bus.cpu_in_rd;
                if (bus.dev_in_valid) begin
                    capture   = 1'b1;
                    nextState = IN_FULL;
                end
            end
            IN_FULL: begin
                bus.cpu_in_avail = 1'b1;
                if (bus.cpu_in_rd) nextState = IN_EMPTY;
            end
        endcase
    end

    // The holding register. It keeps its last word after the word is read, so an underrun read returns that word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          heldData <= '0;
        else if (capture) heldData <= bus.dev_in_data;
    end

    // The sticky error flags. A new error event takes priority over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflowFlag <= 1'b0;
            underrunFlag <= 1'b0;
        end else begin
            if (dropWrite)        overflowFlag <= 1'b1;
            else if (bus.err_clr) overflowFlag <= 1'b0;
            if (underrunEvt)      underrunFlag <= 1'b1;
            else if (bus.err_clr) underrunFlag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge.
// A queue-based reference model of the port rules is stepped once per clock. Directed scenarios and a random soak run against this model.
module tb_io_port_bridge;
    localparam int DATA_W    = 16;
    localparam int OUT_DEPTH = 4;
    localparam int CNT_W     = $clog2(OUT_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    io_port_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    io_port_bridge #(.DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] mQ[$];
    bit                mInFull;
    logic [DATA_W-1:0] mHeld;
    bit                mOvf, mUnd;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mInFull = 0;
        mHeld   = '0;
        mOvf    = 0;
        mUnd    = 0;
    endtask

    // This task applies one clock of the port rules to the model, using the inputs that are currently driven.
    task automatic modelStep();
        bit doPop;
        doPop = (mQ.size() != 0) && bus.dev_out_ready;
        if (bus.err_clr) begin
            mOvf = 0;
            mUnd = 0;
        end
        if (bus.cpu_out_wr && mQ.size() == OUT_DEPTH && !doPop) mOvf = 1;
        if (doPop) void'(mQ.pop_front());
        if (bus.cpu_out_wr && mQ.size() < OUT_DEPTH) mQ.push_back(bus.cpu_out_data);
        if (!mInFull) begin
            if (bus.cpu_in_rd) mUnd = 1;
            if (bus.dev_in_valid) begin
                mHeld   = bus.dev_in_data;
                mInFull = 1;
            end
        end else if (bus.cpu_in_rd) begin
            mInFull = 0;
        end
    endtask

    task automatic checkAll();
        check("out_count", bus.out_count, mQ.size());
        check("out_full", bus.out_full, mQ.size() == OUT_DEPTH);
        check("dev_out_valid", bus.dev_out_valid, mQ.size() != 0);
        if (mQ.size() != 0) check("dev_out_data", bus.dev_out_data, mQ[0]);
        check("dev_in_ready", bus.dev_in_ready, !mInFull);
        check("cpu_in_avail", bus.cpu_in_avail, mInFull);
        check("cpu_in_data", bus.cpu_in_data, mHeld);
        check("out_overflow", bus.out_overflow, mOvf);
        check("in_underrun", bus.in_underrun, mUnd);
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle();
        bus.cpu_out_wr    = 1'b0;
        bus.cpu_out_data  = '0;
        bus.dev_out_ready = 1'b0;
        bus.dev_in_valid  = 1'b0;
        bus.dev_in_data   = '0;
        bus.cpu_in_rd     = 1'b0;
        bus.err_clr       = 1'b0;
    endtask

    task automatic writeWord(input logic [DATA_W-1:0] w);
        bus.cpu_out_wr   = 1'b1;
        bus.cpu_out_data = w;
        cycle();
        bus.cpu_out_wr   = 1'b0;
    endtask

    // This task asserts reset between clock edges and checks that the reset values appear before any edge.
    task automatic resetPulse();
        idle();
        #2 rst = 1'b1;
        #1;
        check("rst_count", bus.out_count, 0);
        check("rst_valid", bus.dev_out_valid, 0);
        check("rst_full", bus.out_full, 0);
        check("rst_in_ready", bus.dev_in_ready, 1);
        check("rst_avail", bus.cpu_in_avail, 0);
        check("rst_in_data", bus.cpu_in_data, 0);
        check("rst_ovf", bus.out_overflow, 0);
        check("rst_und", bus.in_underrun, 0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;
        checkAll();
    endtask

    logic [DATA_W-1:0] seq[4];
    logic [DATA_W-1:0] streamExp[$];
    int sent, got;

    initial begin
        idle();
        modelReset();
        rst = 1'b1;
        #2 checkAll();
        @(posedge clk);
        #1 rst = 1'b0;
        checkAll();

        // Order and latency: fill the FIFO while the device is stalled, then drain it on consecutive cycles.
        seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333; seq[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            writeWord(seq[i]);
            check("fill_head", bus.dev_out_data, 16'h1111);
        end
        check("fill_full", bus.out_full, 1);
        bus.dev_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", bus.dev_out_data, seq[i]);
            check("drain_valid", bus.dev_out_valid, 1);
            cycle();
        end
        check("drain_empty", bus.out_count, 0);
        bus.dev_out_ready = 1'b0;

        // Overflow while full, then a write into a full FIFO while it pops.
        for (int i = 0; i < 4; i++) writeWord(seq[i]);
        writeWord(16'hDEAD);
        check("ovf_flag", bus.out_overflow, 1);
        check("ovf_head", bus.dev_out_data, 16'h1111);
        check("ovf_count", bus.out_count, 4);
        bus.dev_out_ready = 1'b1;
        writeWord(16'hBEEF);
        check("simul_count", bus.out_count, 4);
        seq[0] = 16'h2222; seq[1] = 16'h3333; seq[2] = 16'h4444; seq[3] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            check("simul_order", bus.dev_out_data, seq[i]);
            cycle();
        end
        check("simul_empty", bus.dev_out_valid, 0);
        bus.dev_out_ready = 1'b0;
        bus.err_clr = 1'b1;
        cycle();
        bus.err_clr = 1'b0;
        check("ovf_cleared", bus.out_overflow, 0);

        // Input handshake.
        bus.dev_in_valid = 1'b1;
        bus.dev_in_data  = 16'hA5A5;
        cycle();
        check("in_cap_data", bus.cpu_in_data, 16'hA5A5);
        check("in_cap_avail", bus.cpu_in_avail, 1);
        check("in_cap_ready", bus.dev_in_ready, 0);
        bus.dev_in_data = 16'h5A5A;
        cycle();
        check("in_ignored", bus.cpu_in_data, 16'hA5A5);
        bus.cpu_in_rd = 1'b1;
        cycle();
        bus.cpu_in_rd = 1'b0;
        check("in_read_empty", bus.cpu_in_avail, 0);
        check("in_read_keep", bus.cpu_in_data, 16'hA5A5);
        cycle();
        check("in_next_cap", bus.cpu_in_data, 16'h5A5A);
        check("in_next_avail", bus.cpu_in_avail, 1);
        bus.dev_in_valid = 1'b0;

        // Underrun, clear, and a clear that coincides with a new underrun.
        bus.cpu_in_rd = 1'b1;
        cycle();
        check("und_first_rd", bus.in_underrun, 0);
        cycle();
        check("und_set", bus.in_underrun, 1);
        check("und_data", bus.cpu_in_data, 16'h5A5A);
        bus.cpu_in_rd = 1'b0;
        bus.err_clr   = 1'b1;
        cycle();
        check("und_clear", bus.in_underrun, 0);
        bus.cpu_in_rd = 1'b1;
        cycle();
        check("und_set_wins", bus.in_underrun, 1);
        idle();

        // Reset during traffic, with three words queued and the underrun flag set.
        for (int i = 0; i < 3; i++) writeWord(DATA_W'($urandom));
        check("pre_rst_count", bus.out_count, 3);
        resetPulse();

        // Pointer wrap: stream 10 words with random stalls, and honour out_full on the processor side.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            bus.dev_out_ready = 1'($urandom_range(0, 1));
            if (sent < 10 && !bus.out_full && $urandom_range(0, 3) != 0) begin
                bus.cpu_out_wr   = 1'b1;
                bus.cpu_out_data = DATA_W'($urandom);
                streamExp.push_back(bus.cpu_out_data);
                sent++;
            end else begin
                bus.cpu_out_wr = 1'b0;
            end
            if (bus.dev_out_valid && bus.dev_out_ready) begin
                check("stream_order", bus.dev_out_data, streamExp.pop_front());
                got++;
            end
            cycle();
        end
        check("stream_done", got, 10);
        check("stream_ovf", bus.out_overflow, 0);
        idle();

        // Random soak across both directions and the error flags.
        for (int c = 0; c < 400; c++) begin
            bus.cpu_out_wr    = 1'($urandom_range(0, 1));
            bus.cpu_out_data  = DATA_W'($urandom);
            bus.dev_out_ready = 1'($urandom_range(0, 2) == 0);
            bus.dev_in_valid  = 1'($urandom_range(0, 1));
            bus.dev_in_data   = DATA_W'($urandom);
            bus.cpu_in_rd     = 1'($urandom_range(0, 2) == 0);
            bus.err_clr       = 1'($urandom_range(0, 7) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Connects the processor's OUT/IN port datapath to an external device using valid/ready handshakes in both directions.
- Output direction: OUT-write strobes from the execute stage are queued in a small FIFO, then drained to the device.
- Input direction: words from the device are captured into a one-entry holding register, which the processor consumes on IN.
- Sits at the processor top level, beside the pipeline; an asserted out_full stalls fetch/decode.

Parameters:
- DATA_W, 16, width of port data (matches register/ALU width).
- OUT_DEPTH, 4, output FIFO depth; power of two, at least 2.
- CNT_W, $clog2(OUT_DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_out_wr  in  1  OUT-instruction write strobe, one cycle per word.
- cpu_out_data  in  DATA_W  word to send.
- out_full  out  1  FIFO full; processor stall request.
- out_count  out  CNT_W  current FIFO occupancy.
- dev_out_valid  out  1  FIFO head is valid.
- dev_out_data  out  DATA_W  FIFO head word.
- dev_out_ready  in  1  device accepts the head word.
- dev_in_valid  in  1  device offers a word.
- dev_in_data  in  DATA_W  offered word.
- dev_in_ready  out  1  holding register is empty.
- cpu_in_rd  in  1  IN-instruction read strobe.
- cpu_in_data  out  DATA_W  held input word.
- cpu_in_avail  out  1  held word is unread.
- err_clr  in  1  synchronous clear of the sticky error flags.
- out_overflow  out  1  sticky: a write was dropped.
- in_underrun  out  1  sticky: a read occurred while empty.

Behaviour:
Reset (asynchronous, takes effect immediately):
- Output FIFO: pointers, count and out_overflow go to 0; dev_out_valid=0; out_full=0.
- Input side: FSM goes to IN_EMPTY; cpu_in_data=0; cpu_in_avail=0; dev_in_ready=1; in_underrun=0.

Output FIFO (show-ahead):
- dev_out_valid = (count!=0).
- dev_out_data = mem[rd_ptr], combinational from registered storage.
- out_full = (count==OUT_DEPTH).
- pop = dev_out_valid && dev_out_ready.
- push = cpu_out_wr && (!out_full || pop). A write when full is accepted only if a pop happens in the same cycle.
- cpu_out_wr while full with no pop: the word is dropped, out_overflow is set, and FIFO state is unchanged.
- Pointers are log2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH.
- count updates as +1 for push only, -1 for pop only, unchanged for both or neither.
- Latency: a word pushed at edge N is visible on dev_out_* in the cycle after edge N (one cycle). FIFO order is strict.
- Push into an empty FIFO with dev_out_ready=1: the word is not forwarded in the same cycle (no bypass).
- While dev_out_valid=1 and dev_out_ready=0, dev_out_data must hold stable.

Input FSM, two states:
- IN_EMPTY:
  - dev_in_ready=1, cpu_in_avail=0.
  - dev_in_valid: capture dev_in_data into cpu_in_data, go to IN_FULL.
- IN_FULL:
  - dev_in_ready=0, cpu_in_avail=1.
  - cpu_in_rd: go to IN_EMPTY; cpu_in_data keeps its value.
  - dev_in_valid is ignored; the device must hold its word.
- cpu_in_rd in IN_EMPTY: sets in_underrun; cpu_in_data returns the last held value (0 after reset).
- cpu_in_rd and dev_in_valid in the same cycle while IN_FULL: the read completes; the new word is captured no earlier than the next cycle, because dev_in_ready was 0.

Sticky error flags:
- err_clr clears both flags.
- If err_clr coincides with a new error event in the same cycle, the set wins.

No combinational path from dev_in_valid to dev_in_ready. dev_out_ready reaches only the push acceptance, not out_full.

Test Plan:
- Reset mid-traffic: 3 words queued, then rst pulsed asynchronously between edges → out_count=0, dev_out_valid=0, dev_in_ready=1, all flags 0, immediately without waiting for a clock edge.
- Order and latency: dev_out_ready=0; write 0x1111, 0x2222, 0x3333, 0x4444 → out_full=1 after the 4th edge; raise ready → device receives 0x1111..0x4444 in order on 4 consecutive cycles; then out_count=0.
- Overflow, then full with simultaneous pop:
  - FIFO full, ready=0, write 0xDEAD → dropped; out_overflow=1; head still 0x1111.
  - Then ready=1 and write 0xBEEF in the same cycle → accepted; count stays 4; 0xBEEF emerges last.
- Input handshake:
  - Device offers 0xA5A5 → captured; cpu_in_avail=1, dev_in_ready=0.
  - Device offers 0x5A5A while full → ignored.
  - cpu_in_rd → FSM to IN_EMPTY; the next cycle captures 0x5A5A.
- Underrun and clear:
  - cpu_in_rd while empty → in_underrun=1; cpu_in_data unchanged.
  - err_clr → in_underrun=0.
  - err_clr in the same cycle as another empty read → in_underrun stays 1.
- Pointer wrap: stream 10 words with random ready stalls (OUT_DEPTH=4) → all 10 delivered in order; out_count never exceeds 4; out_overflow stays 0 when the processor honours out_full.
